vga_frame_reader: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 56 +++++
 rtl/vga_frame_reader_if.sv | 37 +++
 rtl/vga_timing_gen.sv | 75 +++++++
 rtl/vga_frame_reader.sv | 107 ++++++++++
 tb/tb_vga_frame_reader.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, widths and inter-block types
// for the VGA frame reader and its timing generator.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int FRAME_PIXELS = 307200;

    localparam int ADDR_W  = 19;
    localparam int COLOR_W = 12;
    localparam int CNT_W   = 10;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [COLOR_W-1:0] rgb_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    typedef struct packed {
        logic pix_ce;
        logic active;
        logic hsync_n;
        logic vsync_n;
        logic frame_last;
        cnt_t hcnt;
        cnt_t vcnt;
    } vga_timing_t;

    // Eight 80-pixel colour bars, left to right.
    function automatic rgb_t bar_color(input cnt_t x);
        rgb_t c;
        if (x < 10'd80)       c = 12'hFFF;
        else if (x < 10'd160) c = 12'hFF0;
        else if (x < 10'd240) c = 12'h0FF;
        else if (x < 10'd320) c = 12'h0F0;
        else if (x < 10'd400) c = 12'hF0F;
        else if (x < 10'd480) c = 12'hF00;
        else if (x < 10'd560) c = 12'h00F;
        else                  c = 12'h000;
        return c;
    endfunction

endpackage

// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port and VGA connector signals of the frame reader.
// master = frame reader side, slave = memory/connector side.
interface vga_frame_reader_if;
    import vga_timing_pkg::*;

    addr_t      raddr_vga;
    rgb_t       rdata_vga;
    logic       hsync;
    logic       vsync;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       frame_start;

    modport master (
        output raddr_vga,
        input  rdata_vga,
        output hsync,
        output vsync,
        output vga_r,
        output vga_g,
        output vga_b,
        output frame_start
    );

    modport slave (
        input  raddr_vga,
        output rdata_vga,
        input  hsync,
        input  vsync,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  frame_start
    );

endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-rate divider, horizontal/vertical counters, active window
// and raw active-low sync for the VGA frame reader.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACT    = H_ACTIVE,
    parameter int H_FPORCH = H_FP,
    parameter int H_SYNCW  = H_SYNC,
    parameter int H_BPORCH = H_BP,
    parameter int V_ACT    = V_ACTIVE,
    parameter int V_FPORCH = V_FP,
    parameter int V_SYNCW  = V_SYNC,
    parameter int V_BPORCH = V_BP
) (
    input  logic        sys_clk,
    input  logic        rst,
    output vga_timing_t tim_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HT  = H_ACT + H_FPORCH + H_SYNCW + H_BPORCH;
    localparam int VT  = V_ACT + V_FPORCH + V_SYNCW + V_BPORCH;
    localparam int HS0 = H_ACT + H_FPORCH;
    localparam int HS1 = HS0 + H_SYNCW - 1;
    localparam int VS0 = V_ACT + V_FPORCH;
    localparam int VS1 = VS0 + V_SYNCW - 1;

    logic [DIV_W-1:0] div_q, div_d;
    cnt_t             hcnt_q, hcnt_d;
    cnt_t             vcnt_q, vcnt_d;
    logic             pix_ce;
    logic             line_end;
    logic             last_line;

    assign pix_ce    = (div_q == DIV_W'(CLK_DIV - 1));
    assign line_end  = (hcnt_q == CNT_W'(HT - 1));
    assign last_line = (vcnt_q == CNT_W'(VT - 1));

    always_comb begin
        div_d  = pix_ce ? '0 : div_q + 1'b1;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pix_ce) begin
            hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
            if (line_end) begin
                vcnt_d = last_line ? '0 : vcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            div_q  <= div_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign tim_o.pix_ce     = pix_ce;
    assign tim_o.hcnt       = hcnt_q;
    assign tim_o.vcnt       = vcnt_q;
    assign tim_o.frame_last = line_end && last_line;
    assign tim_o.active     = (hcnt_q < CNT_W'(H_ACT)) &&
                              (vcnt_q < CNT_W'(V_ACT));
    assign tim_o.hsync_n    = !((hcnt_q >= CNT_W'(HS0)) &&
                                (hcnt_q <= CNT_W'(HS1)));
    assign tim_o.vsync_n    = !((vcnt_q >= CNT_W'(VS0)) &&
                                (vcnt_q <= CNT_W'(VS1)));

endmodule

// File: rtl/vga_frame_reader.sv
// VGA frame reader: frame-buffer address sequencing plus a one-pixel
// colour/sync output pipeline. Optional colour bars: VGA_TEST_PATTERN_EN.
module vga_frame_reader
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int RD_LAT   = 2,
    parameter int H_ACT    = H_ACTIVE,
    parameter int H_FPORCH = H_FP,
    parameter int H_SYNCW  = H_SYNC,
    parameter int H_BPORCH = H_BP,
    parameter int V_ACT    = V_ACTIVE,
    parameter int V_FPORCH = V_FP,
    parameter int V_SYNCW  = V_SYNC,
    parameter int V_BPORCH = V_BP
) (
    input  logic               sys_clk,
    input  logic               rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               test_pattern,
`endif
    vga_frame_reader_if.master bus
);

    localparam int LAST_ADDR = H_ACT * V_ACT - 1;

    if (RD_LAT < 1 || RD_LAT >= CLK_DIV) begin : g_bad_rd_lat
        $error("RD_LAT must lie in 1..CLK_DIV-1");
    end

    vga_timing_t tim;

    vga_timing_gen #(
        .CLK_DIV  (CLK_DIV),
        .H_ACT    (H_ACT),
        .H_FPORCH (H_FPORCH),
        .H_SYNCW  (H_SYNCW),
        .H_BPORCH (H_BPORCH),
        .V_ACT    (V_ACT),
        .V_FPORCH (V_FPORCH),
        .V_SYNCW  (V_SYNCW),
        .V_BPORCH (V_BPORCH)
    ) u_timing (
        .sys_clk (sys_clk),
        .rst     (rst),
        .tim_o   (tim)
    );

    addr_t raddr_q, raddr_d;
    rgb_t  rgb_q, rgb_d;
    rgb_t  pix;
    logic  hs_q, hs_d;
    logic  vs_q, vs_d;
    logic  fs_q, fs_d;
    logic  at_last;

    assign at_last = (raddr_q == ADDR_W'(LAST_ADDR));

    // Stage 0 advances the address; stage 1 captures the pixel just left.
    always_comb begin
        raddr_d = raddr_q;
        rgb_d   = rgb_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        fs_d    = 1'b0;
        pix     = bus.rdata_vga;
`ifdef VGA_TEST_PATTERN_EN
        if (test_pattern) begin
            pix = bar_color(tim.hcnt);
        end
`endif
        if (tim.pix_ce) begin
            if (tim.frame_last) begin
                raddr_d = '0;
            end else if (tim.active && !at_last) begin
                raddr_d = raddr_q + 1'b1;
            end
            rgb_d = tim.active ? pix : '0;
            hs_d  = tim.hsync_n;
            vs_d  = tim.vsync_n;
            fs_d  = (tim.hcnt == '0) && (tim.vcnt == '0);
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            raddr_q <= '0;
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            raddr_q <= raddr_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
        end
    end

    assign bus.raddr_vga   = raddr_q;
    assign bus.hsync       = hs_q;
    assign bus.vsync       = vs_q;
    assign bus.frame_start = fs_q;
    assign {bus.vga_r, bus.vga_g, bus.vga_b} = rgb_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Self-checking bench for vga_frame_reader: per-cycle scoreboard,
// pixel vector table, line/frame timing and mid-frame reset.
module tb_vga_frame_reader;
    import vga_timing_pkg::*;

    // Full-width lines, short frame (12 lines) to keep runs brief.
    localparam int VA  = 6;
    localparam int VF  = 2;
    localparam int VS  = 2;
    localparam int VB  = 2;
    localparam int VT  = VA + VF + VS + VB;
    localparam int HT  = 800;
    localparam int CD  = 4;
    localparam int LAST = VA * 640 - 1;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
    } out_t;

    typedef struct {
        int          x;
        int          y;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        int          raddr;
    } vec_t;

    logic sys_clk = 1'b0;
    logic rst = 1'b0;
    logic tp_on = 1'b0;
    int   n = 0;
    int   total = 0;
    int   bad = 0;
    int   max_addr = 0;

    out_t sbq[$];
    int   hs_f[$], hs_r[$], vs_f[$], vs_r[$], fs_t[$];
    vec_t tv[16];
    int   nt;

    vga_frame_reader_if bus();

    vga_frame_reader #(
        .CLK_DIV  (CD),
        .RD_LAT   (2),
        .V_ACT    (VA),
        .V_FPORCH (VF),
        .V_SYNCW  (VS),
        .V_BPORCH (VB)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
`ifdef VGA_TEST_PATTERN_EN
        .test_pattern (tp_on),
`endif
        .bus          (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // Memory: rdata follows raddr after two clocks.
    logic [18:0] d1, d2;
    always @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            d1 <= '0;
            d2 <= '0;
        end else begin
            d1 <= bus.raddr_vga;
            d2 <= d1;
        end
    end
    assign bus.rdata_vga = d2[11:0];

    always @(posedge sys_clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (n=%0d)", nm, act, exp, n);
        end
    endtask

    function automatic logic [11:0] bar(input int x);
        case (x / 80)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    function automatic int exp_raddr(input int k);
        int x, y;
        x = k % HT;
        y = (k / HT) % VT;
        if (y < VA) begin
            if (x < 640) return y * 640 + x;
            if ((y + 1) * 640 > LAST) return LAST;
            return (y + 1) * 640;
        end
        return LAST;
    endfunction

    function automatic out_t exp_out(input int k);
        int x, y;
        out_t o;
        x = k % HT;
        y = (k / HT) % VT;
        o.fs = (x == 0) && (y == 0);
        o.hs = !(x >= 656 && x <= 751);
        o.vs = !(y >= VA + VF && y <= VA + VF + VS - 1);
        if (x < 640 && y < VA)
            o.rgb = tp_on ? bar(x) : 12'(y * 640 + x);
        else
            o.rgb = 12'h000;
        return o;
    endfunction

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic wait_n(input int tgt);
        int g = 0;
        while (n != tgt && g < 60000) begin
            @(negedge sys_clk);
            g++;
        end
        if (n != tgt) chk("wait_timeout", n, tgt);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < nt; i++) begin
            wait_n(((tv[i].y * HT + tv[i].x) + 1) * CD);
            chk({tag, "_rgb"}, {bus.vga_r, bus.vga_g, bus.vga_b}, tv[i].rgb);
            chk({tag, "_hs"}, bus.hsync, tv[i].hs);
            chk({tag, "_vs"}, bus.vsync, tv[i].vs);
            chk({tag, "_raddr"}, bus.raddr_vga, tv[i].raddr);
        end
    endtask

    // Scoreboard: expected output for a pixel is queued when it becomes
    // current and retired at the pixel edge that displays it.
    initial begin
        out_t        cur;
        logic [33:0] act, expv;
        logic        fsx;
        cur = '{rgb: 12'h0, hs: 1'b1, vs: 1'b1, fs: 1'b0};
        forever begin
            @(negedge sys_clk);
            act = {bus.raddr_vga, bus.vga_r, bus.vga_g, bus.vga_b,
                   bus.hsync, bus.vsync, bus.frame_start};
            if (rst) begin
                sbq.delete();
                sbq.push_back(exp_out(0));
                cur  = '{rgb: 12'h0, hs: 1'b1, vs: 1'b1, fs: 1'b0};
                expv = {19'd0, 12'd0, 3'b110};
            end else begin
                if (n >= CD && n % CD == 0) begin
                    chk("sb_depth", sbq.size(), 1);
                    if (sbq.size() > 0) cur = sbq.pop_front();
                    sbq.push_back(exp_out(n / CD));
                end
                fsx  = cur.fs && (n % CD == 0);
                expv = {19'(exp_raddr(n / CD)), cur.rgb, cur.hs, cur.vs, fsx};
                if (int'(bus.raddr_vga) > max_addr) max_addr = int'(bus.raddr_vga);
            end
            chk("outputs", act, expv);
        end
    end

    initial begin
        logic hp, vp;
        hp = 1'b1;
        vp = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (rst) begin
                hp = 1'b1;
                vp = 1'b1;
            end else begin
                if (hp && !bus.hsync) hs_f.push_back(n);
                if (!hp && bus.hsync) hs_r.push_back(n);
                if (vp && !bus.vsync) vs_f.push_back(n);
                if (!vp && bus.vsync) vs_r.push_back(n);
                if (bus.frame_start) fs_t.push_back(n);
                hp = bus.hsync;
                vp = bus.vsync;
            end
        end
    end

    initial begin
        #2 rst = 1'b1;
        repeat (10) @(negedge sys_clk);
        #1 rst = 1'b0;

        wait_n(3);
        chk("pre_ce_raddr", bus.raddr_vga, 0);
        wait_n(4);
        chk("first_ce_raddr", bus.raddr_vga, 1);
        chk("first_fs", bus.frame_start, 1);

        nt = 16;
        tv[0]  = '{0,   0,  12'h000, 1, 1, 1};
        tv[1]  = '{5,   0,  12'h005, 1, 1, 6};
        tv[2]  = '{639, 0,  12'h27F, 1, 1, 640};
        tv[3]  = '{640, 0,  12'h000, 1, 1, 640};
        tv[4]  = '{655, 0,  12'h000, 1, 1, 640};
        tv[5]  = '{656, 0,  12'h000, 0, 1, 640};
        tv[6]  = '{751, 0,  12'h000, 0, 1, 640};
        tv[7]  = '{752, 0,  12'h000, 1, 1, 640};
        tv[8]  = '{5,   1,  12'h285, 1, 1, 646};
        tv[9]  = '{100, 2,  12'h564, 1, 1, 1381};
        tv[10] = '{639, 5,  12'hEFF, 1, 1, 3839};
        tv[11] = '{640, 5,  12'h000, 1, 1, 3839};
        tv[12] = '{799, 7,  12'h000, 1, 1, 3839};
        tv[13] = '{0,   8,  12'h000, 1, 0, 3839};
        tv[14] = '{0,   9,  12'h000, 1, 0, 3839};
        tv[15] = '{0,   10, 12'h000, 1, 1, 3839};
        run_table("px");

        wait_n(38408);
        chk("hs_fall", qget(hs_f, 0), 2628);
        chk("hs_low", qget(hs_r, 0) - qget(hs_f, 0), 384);
        chk("line_period", qget(hs_f, 1) - qget(hs_f, 0), 3200);
        chk("vs_fall", qget(vs_f, 0), 25604);
        chk("vs_low", qget(vs_r, 0) - qget(vs_f, 0), 6400);
        chk("fs_count", fs_t.size(), 2);
        chk("fs_first", qget(fs_t, 0), 4);
        chk("fs_period", qget(fs_t, 1) - qget(fs_t, 0), 38400);
        chk("addr_max", max_addr, LAST);

        // Reset while at (300,3) of the second frame.
        wait_n((VT * HT + 3 * HT + 300) * CD + 1);
        chk("mid_raddr", bus.raddr_vga, 3 * 640 + 300);
        #1 rst = 1'b1;
        #1;
        chk("arst_raddr", bus.raddr_vga, 0);
        chk("arst_rgb", {bus.vga_r, bus.vga_g, bus.vga_b}, 0);
        chk("arst_sync", {bus.hsync, bus.vsync, bus.frame_start}, 3'b110);
        repeat (5) @(negedge sys_clk);
        hs_f.delete();
        fs_t.delete();
`ifdef VGA_TEST_PATTERN_EN
        tp_on = 1'b1;
`endif
        #1 rst = 1'b0;

        wait_n(4);
        chk("rst_fs", bus.frame_start, 1);
`ifdef VGA_TEST_PATTERN_EN
        nt = 5;
        tv[0] = '{0,   0, 12'hFFF, 1, 1, 1};
        tv[1] = '{79,  0, 12'hFFF, 1, 1, 80};
        tv[2] = '{80,  0, 12'hFF0, 1, 1, 81};
        tv[3] = '{560, 0, 12'h000, 1, 1, 561};
        tv[4] = '{639, 0, 12'h000, 1, 1, 640};
`else
        nt = 3;
        tv[0] = '{0,   0, 12'h000, 1, 1, 1};
        tv[1] = '{5,   1, 12'h285, 1, 1, 646};
        tv[2] = '{640, 1, 12'h000, 1, 1, 1280};
`endif
        run_table("rst");
        chk("rst_fs_once", fs_t.size(), 1);
        chk("rst_fs_at", qget(fs_t, 0), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
